uart_rx_word_packer: RTL and testbench

Consumer stage directly downstream of the UART byte receiver. Detects completion of each received byte from the receiver's busy/data/fault outputs, assembles bytes little-endian into 32-bit words, and buffers them in a small FIFO. The CPU-side bus adapter drains the FIFO over a valid/ready handshake. Also reports framing errors and overflow.

---
 rtl/uart_rx_word_packer_pkg.sv | 27 ++
 rtl/uart_rx_word_packer_fifo.sv | 49 ++++
 rtl/uart_rx_word_packer.sv | 136 +++++++++++++
 tb/tb_uart_rx_word_packer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_word_packer_pkg.sv
// Shared widths, defaults and the FIFO entry layout for the UART receive word packer.
package uart_rx_word_packer_pkg;

    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_W          = BYTE_W * BYTES_PER_WORD;
    localparam int CNT_W           = 3;
    // Idle flush time at 100 MHz / 9600 baud.
    localparam int DEFAULT_TIMEOUT = 10417;

    typedef struct packed {
        logic [CNT_W-1:0]  bytes;
        logic [WORD_W-1:0] data;
    } word_entry_t;

    // Zero every lane at or above nbytes so a partial word carries no stale data.
    function automatic logic [WORD_W-1:0] mask_lanes(input logic [WORD_W-1:0] word,
                                                     input logic [CNT_W-1:0]  nbytes);
        logic [WORD_W-1:0] res;
        res = word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i >= int'(nbytes)) res[BYTE_W*i +: BYTE_W] = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_word_packer_fifo.sv
// rx_word_fifo: DEPTH-entry word FIFO holding data plus byte count; status from a level counter.
module rx_word_fifo
    import uart_rx_word_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  word_entry_t              wr_entry,
    input  logic                     pop,
    output word_entry_t              head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    word_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs UART receiver bytes little-endian into 32-bit words and queues them for the CPU side.
// Optional idle flush of partial words is enabled by defining UART_PACK_TIMEOUT_EN.
module uart_rx_word_packer
    import uart_rx_word_packer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    recv_busy,
    input  logic [7:0]              recv_data,
    input  logic                    fault,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [31:0]             word_data,
    output logic [2:0]              word_bytes,
    output logic [$clog2(DEPTH):0]  level,
    output logic [7:0]              err_cnt,
    output logic                    overflow,
    input  logic                    clear
);

    logic        busy_q;
    logic [1:0]  idx;
    logic [31:0] asm_word;

    logic        byte_done;
    logic        good_byte;
    logic        bad_byte;
    logic        full_word;
    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        flush;
    word_entry_t push_entry;
    word_entry_t head;

    assign byte_done = busy_q & ~recv_busy;
    assign good_byte = byte_done & ~fault;
    assign bad_byte  = byte_done & fault;
    assign full_word = good_byte && (idx == 2'd3);

`ifdef UART_PACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // A byte-done in the same cycle always wins over the idle flush.
    assign flush = !byte_done && (idx != 2'd0) && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (byte_done || flush) begin
            tcnt <= '0;
        end else if (idx != 2'd0) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_comb begin
        push_entry = '0;
        if (full_word) begin
            push_entry.data  = {recv_data, asm_word[23:0]};
            push_entry.bytes = 3'd4;
        end else begin
            push_entry.data  = mask_lanes(asm_word, {1'b0, idx});
            push_entry.bytes = {1'b0, idx};
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign flush          = 1'b0;

    always_comb begin
        push_entry       = '0;
        push_entry.data  = {recv_data, asm_word[23:0]};
        push_entry.bytes = 3'd4;
    end
`endif

    assign push_req   = full_word | flush;
    assign word_valid = !fifo_empty;
    assign pop        = word_valid && word_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            idx      <= 2'd0;
            asm_word <= '0;
        end else begin
            busy_q <= recv_busy;
            if (good_byte) begin
                asm_word[8*idx +: 8] <= recv_data;
                idx                  <= idx + 2'd1;
            end else if (flush) begin
                idx <= 2'd0;
            end
        end
    end

    // Status: clear outranks a same-cycle increment or overflow set.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt  <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (bad_byte && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (drop) overflow <= 1'b1;
        end
    end

    rx_word_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_ok),
        .wr_entry (push_entry),
        .pop      (pop),
        .head     (head),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign word_data  = head.data;
    assign word_bytes = head.bytes;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: framing, faults, overflow, full push/pop, timeout, reset.
module tb_uart_rx_word_packer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        recv_busy = 1'b0;
    logic [7:0]  recv_data = 8'h00;
    logic        fault = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic [2:0]  level;
    logic [7:0]  err_cnt;
    logic        overflow;
    logic        clear = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_rx_word_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .recv_busy  (recv_busy),
        .recv_data  (recv_data),
        .fault      (fault),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_bytes (word_bytes),
        .level      (level),
        .err_cnt    (err_cnt),
        .overflow   (overflow),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    // Returns #1 after the edge that consumes the byte-done.
    task automatic send_byte(input logic [7:0] b, input logic f);
        @(posedge clk); #1 recv_busy = 1'b1;
        @(posedge clk); #1 recv_busy = 1'b0; recv_data = b; fault = f;
        @(posedge clk); #1 fault = 1'b0;
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        @(posedge clk); #1 word_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] base, input int w);
        logic [7:0] b0, b1, b2, b3;
        b0 = base + 8'(4*w);
        b1 = b0 + 8'd1;
        b2 = b0 + 8'd2;
        b3 = b0 + 8'd3;
        return {b3, b2, b1, b0};
    endfunction

    task automatic send_words(input logic [7:0] base, input int nwords);
        logic [31:0] w;
        for (int i = 0; i < nwords; i++) begin
            w = word_of(base, i);
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
        checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", word_data); end
        checks++; if (word_bytes !== 3'd0) begin errors++; $display("FAIL reset_bytes got %0d exp 0", word_bytes); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_four_bytes();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(posedge clk); #1 recv_busy = 1'b1;
        @(posedge clk); #1 recv_busy = 1'b0; recv_data = 8'h44;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL four_early_valid got %b exp 0", word_valid); end
        @(posedge clk); #1;
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL four_latency got %b exp 1", word_valid); end
        checks++; if (word_data !== 32'h44332211) begin errors++; $display("FAIL four_data got %h exp 44332211", word_data); end
        checks++; if (word_bytes !== 3'd4) begin errors++; $display("FAIL four_bytes got %0d exp 4", word_bytes); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL four_level got %0d exp 1", level); end
        pop_one();
        checks++; if (word_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL four_pop got valid %b level %0d exp 0 0", word_valid, level); end
        checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL four_empty_data got %h exp 00000000", word_data); end
    endtask

    task automatic test_fault();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        checks++; if (word_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL fault_word got %h exp ddccbbaa", word_data); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL fault_cnt1 got %0d exp 1", err_cnt); end
        pop_one();
        for (int i = 0; i < 300; i++) send_byte(8'hE7, 1'b1);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL fault_sat got %0d exp 255", err_cnt); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL fault_nopush got level %0d exp 0", level); end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL fault_clear got %0d exp 0", err_cnt); end
    endtask

    task automatic test_overflow();
        send_words(8'h01, 5);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_valid !== 1'b1 || word_data !== word_of(8'h01, i)) begin
                errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, word_data, word_of(8'h01, i));
            end
            pop_one();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_drained got level %0d exp 0", level); end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] nw;
        send_words(8'h80, 4);
        nw = word_of(8'h80, 4);
        send_byte(nw[7:0], 1'b0);
        send_byte(nw[15:8], 1'b0);
        send_byte(nw[23:16], 1'b0);
        @(posedge clk); #1 recv_busy = 1'b1;
        @(posedge clk); #1 recv_busy = 1'b0; recv_data = nw[31:24]; word_ready = 1'b1;
        @(posedge clk); #1 word_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level got %0d exp 4", level); end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (word_valid !== 1'b1 || word_data !== word_of(8'h80, i)) begin
                errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, word_data, word_of(8'h80, i));
            end
            pop_one();
        end
    endtask

    task automatic test_timeout();
        int n;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", word_valid); end
`ifdef UART_PACK_TIMEOUT_EN
        n = 0;
        while (word_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL tmo_flush got valid %b exp 1", word_valid); end
        checks++; if (word_data !== 32'h00000201) begin errors++; $display("FAIL tmo_data got %h exp 00000201", word_data); end
        checks++; if (word_bytes !== 3'd2) begin errors++; $display("FAIL tmo_bytes got %0d exp 2", word_bytes); end
        pop_one();
`else
        n = 0;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL tmo_none got valid %b level %0d exp 0 0", word_valid, level); end
`endif
    endtask

    task automatic test_reset_mid_word();
        send_words(8'h50, 1);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        do_reset();
        #1;
        checks++; if (level !== 3'd0 || word_valid !== 1'b0) begin errors++; $display("FAIL rmw_level got level %0d valid %b exp 0 0", level, word_valid); end
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h40, 1'b0);
        checks++; if (word_data !== 32'h40302010) begin errors++; $display("FAIL rmw_word got %h exp 40302010", word_data); end
        checks++; if (word_bytes !== 3'd4 || level !== 3'd1) begin errors++; $display("FAIL rmw_bytes got bytes %0d level %0d exp 4 1", word_bytes, level); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_four_bytes();
        test_fault();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
